// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/data arbiter for a single-ported variable-latency memory.
// Optional ARB_PERF_CNT_EN adds grant and conflict performance counters.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_resp,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_conflict_cycles
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            r_state;
    logic              r_owner_d;
    logic [3:0]        r_starve_cnt;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_if_done;
    logic              r_d_done;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_grant_d;
    logic              w_grant_if;

    // Data wins unless IF has waited through STARVE_LIMIT consecutive data grants.
    assign w_grant_d  = d_req & (~if_req | (r_starve_cnt < LIMIT));
    assign w_grant_if = if_req & ~w_grant_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_owner_d    <= 1'b0;
            r_starve_cnt <= 4'd0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_done    <= 1'b0;
            r_d_done     <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        r_owner_d   <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_mem_req   <= 1'b1;
                        r_state     <= S_REQ;
                        if (if_req)
                            r_starve_cnt <= (r_starve_cnt < LIMIT) ? r_starve_cnt + 4'd1 : r_starve_cnt;
                        else
                            r_starve_cnt <= 4'd0;
                    end else if (w_grant_if) begin
                        r_owner_d    <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= if_addr;
                        r_mem_wdata  <= '0;
                        r_mem_req    <= 1'b1;
                        r_state      <= S_REQ;
                        r_starve_cnt <= 4'd0;
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp) begin
                        r_state <= S_RESP;
                        if (r_owner_d) begin
                            r_d_done  <= 1'b1;
                            r_d_rdata <= r_mem_we ? '0 : mem_rdata;
                        end else begin
                            r_if_done  <= 1'b1;
                            r_if_rdata <= mem_rdata;
                        end
                    end
                end
                S_RESP: begin
                    r_if_done  <= 1'b0;
                    r_d_done   <= 1'b0;
                    r_if_rdata <= '0;
                    r_d_rdata  <= '0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_perf_if;
    logic [31:0] r_perf_d;
    logic [31:0] r_perf_conflict;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_if       <= '0;
            r_perf_d        <= '0;
            r_perf_conflict <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_grant_d)
                r_perf_d <= r_perf_d + 32'd1;
            if (w_grant_if)
                r_perf_if <= r_perf_if + 32'd1;
            if (if_req & d_req)
                r_perf_conflict <= r_perf_conflict + 32'd1;
        end
    end

    assign perf_if_grants       = r_perf_if;
    assign perf_d_grants        = r_perf_d;
    assign perf_conflict_cycles = r_perf_conflict;
`endif

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_done   = r_if_done;
    assign d_done    = r_d_done;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign if_stall  = if_req & ~r_if_done;
    assign d_stall   = d_req & ~r_d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a responding memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_done, if_stall, d_req, d_we, d_done, d_stall;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_resp;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_grants, perf_d_grants, perf_conflict_cycles;
`endif

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          done_seen = 0;
    bit          if_auto_drop = 1'b1;
    bit          d_auto_drop = 1'b1;
    int          gnt_delay = 0;
    int          resp_delay = 1;
    bit          use_ovr = 1'b0;
    logic [31:0] rdata_ovr = 32'h0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(3)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_done(d_done), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants),
        .perf_conflict_cycles(perf_conflict_cycles)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h3C5A_0000) + 32'h0000_1111;
    endfunction

    // Memory model: grant after gnt_delay cycles, respond resp_delay cycles after grant.
    initial begin : mem_model
        logic [31:0] a;
        mem_gnt = 1'b0; mem_resp = 1'b0; mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                repeat (gnt_delay) @(negedge clk);
                mem_gnt = 1'b1;
                a = mem_addr;
                @(negedge clk);
                mem_gnt = 1'b0;
                repeat (resp_delay - 1) @(negedge clk);
                mem_resp  = 1'b1;
                mem_rdata = use_ovr ? rdata_ovr : mem_word(a);
                @(negedge clk);
                mem_resp  = 1'b0;
                mem_rdata = 32'h0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_done || d_done) begin
                done_seen++;
                checks++;
                if (if_done && d_done) begin
                    errors++;
                    $display("FAIL both_done if_done=%0b d_done=%0b required one", if_done, d_done);
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done if_done=%0b d_done=%0b required none", if_done, d_done);
                end else begin
                    e = sb.pop_front();
                    if (d_done !== e.is_d || (e.is_d ? d_rdata : if_rdata) !== e.rdata
                        || (e.is_d ? if_rdata : d_rdata) !== 32'h0) begin
                        errors++;
                        $display("FAIL sb_done d_done=%0b d_rdata=%h if_rdata=%h required is_d=%0b rdata=%h other=0",
                                 d_done, d_rdata, if_rdata, e.is_d, e.rdata);
                    end
                end
                if (if_done && if_auto_drop) if_req = 1'b0;
                if (d_done && d_auto_drop) d_req = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_mem_req(input string name);
        int n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL %s_mem_req_timeout mem_req=%0b required 1", name, mem_req);
        end
    endtask

    task automatic test_reset();
        if_req = 1'b1; d_req = 1'b0; d_we = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_req, mem_we, if_done, d_done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl req/we/ifd/dd=%b required 0000", {mem_req, mem_we, if_done, d_done});
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem_fields addr=%h wdata=%h required 0", mem_addr, mem_wdata);
        end
        checks++;
        if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata if=%h d=%h required 0", if_rdata, d_rdata);
        end
        checks++;
        if (if_stall !== 1'b1 || d_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall if_stall=%0b d_stall=%0b required 1 0", if_stall, d_stall);
        end
        checks++;
        if (dut.r_starve_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_starve starve_cnt=%0d required 0", dut.r_starve_cnt);
        end
        if_req = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lone_if();
        int k;
        int dd = 0;
        gnt_delay = 0; resp_delay = 3;
        use_ovr = 1'b1; rdata_ovr = 32'h0050_0093;
        if_addr = 32'h40;
        sb.push_back('{is_d: 1'b0, rdata: 32'h0050_0093});
        if_req = 1'b1;
        for (k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (d_done) dd++;
            if (if_done) break;
        end
        checks++;
        if (k !== 5) begin
            errors++;
            $display("FAIL lone_if_latency cycles=%0d required 5", k);
        end
        checks++;
        if (dd !== 0) begin
            errors++;
            $display("FAIL lone_if_d_done count=%0d required 0", dd);
        end
        wait_drain("lone_if", 10);
        use_ovr = 1'b0; resp_delay = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_priority();
        apply_reset();
        if_addr = 32'h200;
        d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        sb.push_back('{is_d: 1'b1, rdata: 32'h0});
        sb.push_back('{is_d: 1'b0, rdata: mem_word(32'h200)});
        if_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
            errors++;
            $display("FAIL prio_req mem_req=%0b mem_we=%0b required 1 1", mem_req, mem_we);
        end
        checks++;
        if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL prio_fields addr=%h wdata=%h required 00000100 deadbeef", mem_addr, mem_wdata);
        end
        wait_drain("priority", 30);
`ifdef ARB_PERF_CNT_EN
        checks++;
        if (perf_conflict_cycles !== 32'd1 || perf_d_grants !== 32'd1 || perf_if_grants !== 32'd1) begin
            errors++;
            $display("FAIL perf_counts conflict=%0d d=%0d if=%0d required 1 1 1",
                     perf_conflict_cycles, perf_d_grants, perf_if_grants);
        end
`endif
        d_we = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_starvation();
        int nd = 0;
        bit got_if = 1'b0;
        if_addr = 32'h300;
        d_we = 1'b0; d_addr = 32'h500;
        for (int i = 0; i < 3; i++) sb.push_back('{is_d: 1'b1, rdata: mem_word(32'h500)});
        sb.push_back('{is_d: 1'b0, rdata: mem_word(32'h300)});
        d_auto_drop = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (d_done) nd++;
            if (if_done) begin
                d_req = 1'b0;
                got_if = 1'b1;
                break;
            end
        end
        checks++;
        if (got_if !== 1'b1 || nd !== 3) begin
            errors++;
            $display("FAIL starve_order if_served=%0b data_before=%0d required 1 3", got_if, nd);
        end
        d_auto_drop = 1'b1;
        wait_drain("starve", 10);
        repeat (2) @(negedge clk);
        checks++;
        if (dut.r_starve_cnt !== 4'd0) begin
            errors++;
            $display("FAIL starve_clear starve_cnt=%0d required 0", dut.r_starve_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        resp_delay = 4;
        d_we = 1'b0; d_addr = 32'h600;
        d_req = 1'b1;
        wait_mem_req("reset_mid");
        @(negedge clk);
        reset = 1'b1;
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_mem mem_req=%0b addr=%h required 0 0", mem_req, mem_addr);
        end
        checks++;
        if (dut.r_state != 2'd0) begin
            errors++;
            $display("FAIL reset_mid_state state=%0d required 0", dut.r_state);
        end
        reset = 1'b0;
        base = done_seen;
        repeat (8) @(negedge clk);
        checks++;
        if (done_seen !== base) begin
            errors++;
            $display("FAIL reset_mid_done pulses=%0d required 0", done_seen - base);
        end
        resp_delay = 1;
    endtask

    task automatic test_gnt_stall();
        gnt_delay = 5;
        d_we = 1'b0; d_addr = 32'h700;
        sb.push_back('{is_d: 1'b1, rdata: mem_word(32'h700)});
        d_req = 1'b1;
        wait_mem_req("gnt_stall");
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h700 || d_stall !== 1'b1) begin
                errors++;
                $display("FAIL gnt_hold_%0d mem_req=%0b addr=%h d_stall=%0b required 1 00000700 1",
                         k, mem_req, mem_addr, d_stall);
            end
            @(negedge clk);
        end
        wait_drain("gnt_stall", 20);
        gnt_delay = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_lone_if();
        test_priority();
        test_starvation();
        test_reset_mid();
        test_gnt_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
